// File: rtl/gpu_cmd_pkg.sv
// Shared types and field layout for the GPU input command word.
package gpu_cmd_pkg;

  localparam int unsigned CMD_W       = 96;
  localparam int unsigned OP_W        = 4;
  localparam int unsigned COLOR_W     = 24;
  localparam int unsigned COORD_W_DEF = 10;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  // LSB position of each field inside the 96-bit word; [27:0] is reserved.
  localparam int unsigned OP_LSB    = 92;
  localparam int unsigned COLOR_LSB = 68;
  localparam int unsigned X1_LSB    = 58;
  localparam int unsigned Y1_LSB    = 48;
  localparam int unsigned X2_LSB    = 38;
  localparam int unsigned Y2_LSB    = 28;

  typedef enum logic [OP_W-1:0] {
    OP_NOP       = 4'd0,
    OP_PIXEL     = 4'd1,
    OP_LINE      = 4'd2,
    OP_RECT      = 4'd3,
    OP_FILL_RECT = 4'd4,
    OP_CLEAR     = 4'd5
  } cmd_op_t;

  typedef struct packed {
    cmd_op_t                  opcode;
    logic [COLOR_W-1:0]       color;
    logic [COORD_W_DEF-1:0]   x1;
    logic [COORD_W_DEF-1:0]   y1;
    logic [COORD_W_DEF-1:0]   x2;
    logic [COORD_W_DEF-1:0]   y2;
  } gpu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cmd_decode.sv
// Combinational split of a FIFO word into command fields plus legality check.
module cmd_decode
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic [CMD_W-1:0] word,
  output gpu_cmd_t         cmd,
  output logic             legal,
  output logic             is_nop
);

  logic x1_ok, y1_ok, x2_ok, y2_ok;
  logic unused_rsvd;

  // Reserved low bits carry no meaning for the reader.
  assign unused_rsvd = ^word[Y2_LSB-1:0];

  // Field extraction, coordinate range checks and per-opcode legality.
  always_comb begin
    cmd.opcode = cmd_op_t'(word[OP_LSB +: OP_W]);
    cmd.color  = word[COLOR_LSB +: COLOR_W];
    cmd.x1     = word[X1_LSB +: COORD_W_DEF];
    cmd.y1     = word[Y1_LSB +: COORD_W_DEF];
    cmd.x2     = word[X2_LSB +: COORD_W_DEF];
    cmd.y2     = word[Y2_LSB +: COORD_W_DEF];

    x1_ok = 32'(cmd.x1) < H_RES;
    y1_ok = 32'(cmd.y1) < V_RES;
    x2_ok = 32'(cmd.x2) < H_RES;
    y2_ok = 32'(cmd.y2) < V_RES;

    legal  = 1'b0;
    is_nop = 1'b0;
    case (cmd.opcode)
      OP_NOP:                         is_nop = 1'b1;
      OP_PIXEL:                       legal  = x1_ok && y1_ok;
      OP_LINE, OP_RECT, OP_FILL_RECT: legal  = x1_ok && y1_ok && x2_ok && y2_ok;
      OP_CLEAR:                       legal  = 1'b1;
      default:                        legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmd_fifo_reader.sv
// Consumer end of the GPU command FIFO: pops, decodes, filters and presents
// legal commands to the rasteriser over a valid/ready handshake.
module cmd_fifo_reader
  import gpu_cmd_pkg::*;
#(
  parameter int unsigned DATA_W  = CMD_W,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned H_RES   = H_RES_DEF,
  parameter int unsigned V_RES   = V_RES_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fifo_empty,
  input  logic [DATA_W-1:0]  fifo_r_data,
  output logic               fifo_r_enable,
  input  logic               flush,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [3:0]         opcode,
  output logic [23:0]        color,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic               cmd_error,
  output logic               busy
);

  rd_state_t state, state_nxt;
  gpu_cmd_t  dec_cmd, cmd_q;
  logic      dec_legal, dec_nop;
  logic      pop, load, err_nxt;

  cmd_decode #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_decode (
    .word   (fifo_r_data),
    .cmd    (dec_cmd),
    .legal  (dec_legal),
    .is_nop (dec_nop)
  );

  // Pop strobe; gated by n_rst so it drops immediately while reset is held.
  always_comb begin
    pop = 1'b0;
    if (n_rst && !fifo_empty) begin
      case (state)
        ST_IDLE:  pop = !flush;
        ST_HOLD:  pop = !flush && cmd_ready;
        ST_DRAIN: pop = 1'b1;
        default:  pop = 1'b0;
      endcase
    end
  end

  // Next state, field load and error pulse; flush overrides everything.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_nxt   = 1'b0;
    if (flush) begin
      state_nxt = ST_DRAIN;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (pop) begin
            if (dec_legal) begin
              state_nxt = ST_HOLD;
              load      = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              err_nxt   = !dec_nop;
            end
          end else if (state == ST_HOLD && cmd_ready) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, error pulse and held command registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      cmd_error <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state     <= state_nxt;
      cmd_error <= err_nxt;
      if (load) cmd_q <= dec_cmd;
    end
  end

  assign fifo_r_enable = pop;
  assign cmd_valid     = (state == ST_HOLD);
  assign busy          = (state != ST_IDLE);
  assign opcode        = cmd_q.opcode;
  assign color         = cmd_q.color;
  assign x1            = cmd_q.x1;
  assign y1            = cmd_q.y1;
  assign x2            = cmd_q.x2;
  assign y2            = cmd_q.y2;

endmodule

// File: tb/tb_cmd_fifo_reader.sv
// Directed bench for cmd_fifo_reader: vector table plus multi-cycle sequences.
module tb_cmd_fifo_reader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        fifo_empty = 1'b1;
  logic [95:0] fifo_r_data = '0;
  logic        fifo_r_enable;
  logic        flush;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  opcode;
  logic [23:0] color;
  logic [9:0]  x1, y1, x2, y2;
  logic        cmd_error;
  logic        busy;

  // Bench FIFO: main process owns mem/wr_ptr, FIFO process owns rd_ptr.
  logic [95:0] mem [64];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pops = 0;
  int unsigned underflow = 0;
  logic        pop_now = 1'b0;

  int checks = 0;
  int errors = 0;

  cmd_fifo_reader #(
    .DATA_W  (96),
    .COORD_W (10),
    .H_RES   (640),
    .V_RES   (480)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fifo_empty    (fifo_empty),
    .fifo_r_data   (fifo_r_data),
    .fifo_r_enable (fifo_r_enable),
    .flush         (flush),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .opcode        (opcode),
    .color         (color),
    .x1            (x1),
    .y1            (y1),
    .x2            (x2),
    .y2            (y2),
    .cmd_error     (cmd_error),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  // Show-ahead FIFO model: refresh head after inputs settle, pop on strobe.
  initial forever begin
    @(negedge clk);
    #2;
    fifo_empty  = (rd_ptr == wr_ptr);
    fifo_r_data = mem[rd_ptr[5:0]];
    #2;
    pop_now = fifo_r_enable;
    @(posedge clk);
    #1;
    if (pop_now) begin
      if (rd_ptr != wr_ptr) rd_ptr = rd_ptr + 1;
      else underflow = underflow + 1;
      pops = pops + 1;
    end
    fifo_empty  = (rd_ptr == wr_ptr);
    fifo_r_data = mem[rd_ptr[5:0]];
  end

  typedef struct {
    logic [3:0]  op;
    logic [23:0] col;
    logic [9:0]  x1, y1, x2, y2;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  function automatic logic [95:0] mk(input logic [3:0] op, input logic [23:0] col,
                                     input logic [9:0] a, input logic [9:0] b,
                                     input logic [9:0] c, input logic [9:0] d);
    return {op, col, a, b, c, d, 28'h5A5A5A5};
  endfunction

  task automatic push(input logic [95:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int unsigned p0;
  int          stray;

  initial begin
    vecs[0]  = '{4'd2, 24'hFF8000, 10'd10,   10'd20,  10'd630,  10'd470, 1'b1, 1'b0};
    vecs[1]  = '{4'd9, 24'h123456, 10'd1,    10'd1,   10'd1,    10'd1,   1'b0, 1'b1};
    vecs[2]  = '{4'd1, 24'h00FF00, 10'd640,  10'd5,   10'd0,    10'd0,   1'b0, 1'b1};
    vecs[3]  = '{4'd5, 24'h0000FF, 10'd1023, 10'd1023,10'd1023, 10'd1023,1'b1, 1'b0};
    vecs[4]  = '{4'd0, 24'hABCDEF, 10'd1,    10'd2,   10'd3,    10'd4,   1'b0, 1'b0};
    vecs[5]  = '{4'd1, 24'h111111, 10'd639,  10'd479, 10'd0,    10'd0,   1'b1, 1'b0};
    vecs[6]  = '{4'd1, 24'h222222, 10'd5,    10'd480, 10'd0,    10'd0,   1'b0, 1'b1};
    vecs[7]  = '{4'd2, 24'h333333, 10'd5,    10'd5,   10'd640,  10'd5,   1'b0, 1'b1};
    vecs[8]  = '{4'd1, 24'h444444, 10'd7,    10'd8,   10'd1023, 10'd1023,1'b1, 1'b0};
    vecs[9]  = '{4'd4, 24'h555555, 10'd0,    10'd0,   10'd639,  10'd480, 1'b0, 1'b1};
    vecs[10] = '{4'd15,24'h666666, 10'd0,    10'd0,   10'd0,    10'd0,   1'b0, 1'b1};
    vecs[11] = '{4'd3, 24'h777777, 10'd0,    10'd0,   10'd0,    10'd0,   1'b1, 1'b0};

    n_rst = 1'b0;
    flush = 1'b0;
    cmd_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst cmd_error", cmd_error, 0);
    chk("rst busy", busy, 0);
    chk("rst pop", fifo_r_enable, 0);
    chk("rst opcode", opcode, 0);
    chk("rst color", color, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Single-word vectors from IDLE with cmd_ready=1
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      push(mk(vecs[i].op, vecs[i].col, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2));
      cmd_ready = 1'b1;
      #3;
      chk($sformatf("v%0d pop", i), fifo_r_enable, 1);
      @(negedge clk);
      #3;
      chk($sformatf("v%0d cmd_valid", i), cmd_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d cmd_error", i), cmd_error, vecs[i].exp_err);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d opcode", i), opcode, vecs[i].op);
        chk($sformatf("v%0d color", i), color, vecs[i].col);
        chk($sformatf("v%0d x1", i), x1, vecs[i].x1);
        chk($sformatf("v%0d y1", i), y1, vecs[i].y1);
        chk($sformatf("v%0d x2", i), x2, vecs[i].x2);
        chk($sformatf("v%0d y2", i), y2, vecs[i].y2);
      end
      @(negedge clk);
      #3;
      chk($sformatf("v%0d after valid", i), cmd_valid, 0);
      chk($sformatf("v%0d after error", i), cmd_error, 0);
      chk($sformatf("v%0d after busy", i), busy, 0);
    end

    // Backpressure: three words, cmd_ready low for five cycles
    @(negedge clk);
    cmd_ready = 1'b0;
    p0 = pops;
    push(mk(4'd1, 24'hA00001, 10'd100, 10'd1, 10'd0, 10'd0));
    push(mk(4'd1, 24'hA00002, 10'd200, 10'd2, 10'd0, 10'd0));
    push(mk(4'd1, 24'hA00003, 10'd300, 10'd3, 10'd0, 10'd0));
    #3;
    chk("bp first pop", fifo_r_enable, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #3;
      chk($sformatf("bp%0d valid", k), cmd_valid, 1);
      chk($sformatf("bp%0d x1", k), x1, 100);
      chk($sformatf("bp%0d color", k), color, 24'hA00001);
      chk($sformatf("bp%0d pop", k), fifo_r_enable, 0);
    end
    chk("bp pops held", pops - p0, 1);
    @(negedge clk);
    cmd_ready = 1'b1;
    #3;
    chk("bp ready pop", fifo_r_enable, 1);
    chk("bp A still", x1, 100);
    @(negedge clk);
    #3;
    chk("bp B valid", cmd_valid, 1);
    chk("bp B x1", x1, 200);
    chk("bp B pop", fifo_r_enable, 1);
    @(negedge clk);
    #3;
    chk("bp C valid", cmd_valid, 1);
    chk("bp C x1", x1, 300);
    chk("bp C y1", y1, 3);
    @(negedge clk);
    #3;
    chk("bp end valid", cmd_valid, 0);
    chk("bp pops total", pops - p0, 3);

    // NOP followed by PIXEL
    @(negedge clk);
    push(mk(4'd0, 24'hFFFFFF, 10'd1, 10'd1, 10'd1, 10'd1));
    push(mk(4'd1, 24'h0A0B0C, 10'd33, 10'd44, 10'd0, 10'd0));
    #3;
    chk("nop pop", fifo_r_enable, 1);
    @(negedge clk);
    #3;
    chk("nop valid", cmd_valid, 0);
    chk("nop error", cmd_error, 0);
    chk("nop pixel pop", fifo_r_enable, 1);
    @(negedge clk);
    #3;
    chk("pix valid", cmd_valid, 1);
    chk("pix opcode", opcode, 1);
    chk("pix x1", x1, 33);
    chk("pix error", cmd_error, 0);
    @(negedge clk);
    #3;
    chk("pix done", cmd_valid, 0);

    // Flush while holding a command with four words queued
    @(negedge clk);
    cmd_ready = 1'b0;
    push(mk(4'd3, 24'h010203, 10'd1, 10'd2, 10'd3, 10'd4));
    #3;
    chk("fl load pop", fifo_r_enable, 1);
    @(negedge clk);
    #3;
    chk("fl hold valid", cmd_valid, 1);
    p0 = pops;
    push(mk(4'd2, 24'h0, 10'd1, 10'd1, 10'd1, 10'd1));
    push(mk(4'd9, 24'h0, 10'd0, 10'd0, 10'd0, 10'd0));
    push(mk(4'd0, 24'h0, 10'd0, 10'd0, 10'd0, 10'd0));
    push(mk(4'd1, 24'h0, 10'd900, 10'd0, 10'd0, 10'd0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #3;
    chk("fl valid", cmd_valid, 0);
    chk("fl error", cmd_error, 0);
    chk("fl busy", busy, 1);
    chk("fl drain pop", fifo_r_enable, 1);
    stray = 0;
    for (int k = 0; k < 12 && busy; k++) begin
      @(negedge clk);
      #3;
      if (cmd_valid || cmd_error) stray = stray + 1;
    end
    chk("fl stray outputs", stray, 0);
    chk("fl busy end", busy, 0);
    chk("fl pop end", fifo_r_enable, 0);
    chk("fl pops", pops - p0, 4);

    // Asynchronous reset while holding, with another word available
    @(negedge clk);
    cmd_ready = 1'b0;
    push(mk(4'd1, 24'hBEEF00, 10'd11, 10'd12, 10'd0, 10'd0));
    push(mk(4'd1, 24'hBEEF01, 10'd13, 10'd14, 10'd0, 10'd0));
    @(negedge clk);
    cmd_ready = 1'b1;
    #3;
    chk("rs hold valid", cmd_valid, 1);
    chk("rs hold pop", fifo_r_enable, 1);
    n_rst = 1'b0;
    #1;
    chk("rs valid", cmd_valid, 0);
    chk("rs pop", fifo_r_enable, 0);
    chk("rs error", cmd_error, 0);
    chk("rs busy", busy, 0);
    chk("rs x1", x1, 0);
    wr_ptr = rd_ptr;
    cmd_ready = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rs idle valid", cmd_valid, 0);
    chk("rs idle busy", busy, 0);
    chk("rs idle pop", fifo_r_enable, 0);

    chk("no underflow pops", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
